// File: rtl/irq_pkg.sv
// ============================================================================
// Module      : irq_pkg
// Description : Shared types and constants for the interrupt vector
//               controller: FSM state encoding, id-width helper and the
//               default vector table placement.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  // Default placement of the vector table
  localparam logic [15:0] DEF_VEC_BASE   = 16'h0f80;
  localparam logic [15:0] DEF_VEC_STRIDE = 16'h0020;

  // Width of a source index; never narrower than one bit
  function automatic int irq_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync_edge.sv
// ============================================================================
// Module      : irq_sync_edge
// Description : Multi-flop synchroniser for one asynchronous source followed
//               by a registered rising-edge detector. The detector is armed
//               only once the synchroniser has refilled after reset, so a
//               source that is already high at reset release raises no edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_arm;
  logic                   r_prev;

  // Synchronise, arm after reset settling, and register a one-cycle rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_arm  <= '0;
      r_prev <= 1'b0;
      rise   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], src};
      r_arm  <= {r_arm[SYNC_STAGES-1:0], 1'b1};
      r_prev <= r_sync[SYNC_STAGES-1];
      rise   <= r_arm[SYNC_STAGES] & r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_vector_ctrl.sv
// ============================================================================
// Module      : irq_vector_ctrl
// Description : Interrupt vector controller. Synchronised, edge-latched,
//               maskable sources; fixed priority (highest index wins);
//               registered request/take handshake towards the execute stage
//               and a service stack popped by handler RET.
//               Optional nesting/preemption is enabled by defining
//               IRQ_NEST_EN; without it only one handler is active at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_vector_ctrl
  import irq_pkg::*;
#(
  parameter int              NUM_SRC     = 4,
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] VEC_BASE    = PC_W'(DEF_VEC_BASE),
  parameter logic [PC_W-1:0] VEC_STRIDE  = PC_W'(DEF_VEC_STRIDE),
  parameter int              SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              src_in,
  input  logic [NUM_SRC-1:0]              mask,
  input  logic                            irq_take,
  input  logic                            irq_ret,
  output logic                            irq_req,
  output logic [PC_W-1:0]                 irq_vec,
  output logic [irq_id_w(NUM_SRC)-1:0]    irq_id,
  output logic                            in_service,
  output logic [NUM_SRC-1:0]              pending
);

  localparam int ID_W = irq_id_w(NUM_SRC);

  irq_state_t         r_state;
  // Service stack held as a set of active ids: strict priority means the
  // stack is always ordered by id, so the top is simply the highest set bit.
  logic [NUM_SRC-1:0] r_active;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_elig;
  logic               w_win_valid;
  logic [ID_W-1:0]    w_win_id;
  logic [ID_W-1:0]    w_top_id;
  logic [PC_W-1:0]    w_vec;
  logic [NUM_SRC-1:0] w_take_bit;
  logic [NUM_SRC-1:0] w_pop_bit;
  logic [NUM_SRC-1:0] w_active_pop;
  logic               w_preempt;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .src   (src_in[gi]),
        .rise  (w_rise[gi])
      );
    end
  endgenerate

  // Priority encoders: winning eligible source and current stack top
  always_comb begin
    w_elig      = pending & mask;
    w_win_valid = 1'b0;
    w_win_id    = '0;
    w_top_id    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_elig[i]) begin
        w_win_valid = 1'b1;
        w_win_id    = ID_W'(i);
      end
      if (r_active[i]) begin
        w_top_id = ID_W'(i);
      end
    end
  end

  // Vector of the winner; wraps modulo 2^PC_W by construction
  always_comb begin
    w_vec = VEC_BASE + PC_W'(NUM_SRC - 1 - int'(w_win_id)) * VEC_STRIDE;
  end

  assign w_take_bit   = (r_state == ST_REQ && irq_take) ? (NUM_SRC'(1) << irq_id) : '0;
  assign w_pop_bit    = NUM_SRC'(1) << w_top_id;
  assign w_active_pop = r_active & ~w_pop_bit;

`ifdef IRQ_NEST_EN
  assign w_preempt = w_win_valid && (w_win_id > w_top_id);
`else
  assign w_preempt = 1'b0;
`endif

  // Pending bits: a new edge on the same bit beats the take-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~w_take_bit) | w_rise;
    end
  end

  // Request/take/service FSM with registered outputs and service stack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_active   <= '0;
      irq_req    <= 1'b0;
      irq_vec    <= '0;
      irq_id     <= '0;
      in_service <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_state <= ST_REQ;
            irq_req <= 1'b1;
            irq_id  <= w_win_id;
            irq_vec <= w_vec;
          end
        end
        ST_REQ: begin
          // id/vector stay frozen here even if priorities or masks change
          if (irq_take) begin
            r_state    <= ST_SERVICE;
            irq_req    <= 1'b0;
            in_service <= 1'b1;
            r_active   <= r_active | w_take_bit;
          end
        end
        ST_SERVICE: begin
          if (irq_ret) begin
            r_active <= w_active_pop;
            if (w_active_pop == '0) begin
              r_state    <= ST_IDLE;
              in_service <= 1'b0;
            end
          end else if (w_preempt) begin
            r_state <= ST_REQ;
            irq_req <= 1'b1;
            irq_id  <= w_win_id;
            irq_vec <= w_vec;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
